line_buffer_window_gen: RTL

//  Streaming 3x3 window generator feeding the 3x3 convolution stage (box blur, etc.).

---
 rtl/line_buffer_window_gen_if.sv | 27 ++
 rtl/line_buffer_window_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/line_buffer_window_gen_if.sv
// Pixel-stream bus for the 3x3 window generator: 8-bit raster input beats in,
// packed 72-bit windows and frame-done pulse out.
interface line_buffer_window_gen_if;
   logic [7:0]  i_pixel_data;
   logic        i_pixel_data_valid;
   logic [71:0] o_pixel_data;
   logic        o_pixel_data_valid;
   logic        o_frame_done;

   // Pixel source / window consumer side
   modport master (
      output i_pixel_data,
      output i_pixel_data_valid,
      input  o_pixel_data,
      input  o_pixel_data_valid,
      input  o_frame_done
   );

   // Window generator side
   modport slave (
      input  i_pixel_data,
      input  i_pixel_data_valid,
      output o_pixel_data,
      output o_pixel_data_valid,
      output o_frame_done
   );
endinterface

// File: rtl/line_buffer_window_gen.sv
// Streaming 3x3 window generator: two row line buffers plus per-row horizontal taps,
// one registered window per accepted beat at x>=2 of rows 2..IMG_HEIGHT-1.
module line_buffer_window_gen #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   line_buffer_window_gen_if.slave     bus
);

   localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
   localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

   typedef enum logic {S_FILL, S_STREAM} state_t;

   state_t          state_reg;
   logic [CW-1:0]   col_reg;
   logic [CW-1:0]   col_next;
   logic [RW-1:0]   row_reg;
   logic            beat;
   logic            last_col;
   logic            last_row;

   logic [7:0]      lb_mid_mem [IMG_WIDTH];
   logic [7:0]      lb_top_mem [IMG_WIDTH];
   logic [7:0]      mid_rd_reg;
   logic [7:0]      top_rd_reg;

   logic [7:0]      hist_reg [3][2];
   logic [7:0]      row_in   [3];
   logic [71:0]     win_next;

   logic [71:0]     win_reg;
   logic            win_valid_reg;
   logic            frame_done_reg;

   // A beat coinciding with reset is dropped entirely.
   assign beat     = bus.i_pixel_data_valid && !i_rst;
   assign last_col = (col_reg == CW'(IMG_WIDTH - 1));
   assign last_row = (row_reg == RW'(IMG_HEIGHT - 1));

   always_comb begin
      col_next = col_reg;
      if (i_rst) begin
         col_next = '0;
      end else if (beat) begin
         col_next = last_col ? '0 : col_reg + CW'(1);
      end
   end

   // Reads are issued one beat ahead at the next column, so the registered read data
   // is already the old contents when that column's beat arrives and rewrites it.
   always_ff @(posedge i_clk) begin
      if (beat) begin
         lb_mid_mem[col_reg] <= bus.i_pixel_data;
         lb_top_mem[col_reg] <= mid_rd_reg;
      end
      mid_rd_reg <= lb_mid_mem[col_next];
      top_rd_reg <= lb_top_mem[col_next];
   end

   assign row_in[0] = top_rd_reg;
   assign row_in[1] = mid_rd_reg;
   assign row_in[2] = bus.i_pixel_data;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_row
         assign win_next[(gi*3 + 0)*8 +: 8] = hist_reg[gi][0];
         assign win_next[(gi*3 + 1)*8 +: 8] = hist_reg[gi][1];
         assign win_next[(gi*3 + 2)*8 +: 8] = row_in[gi];

         always_ff @(posedge i_clk) begin
            if (beat) begin
               hist_reg[gi][0] <= hist_reg[gi][1];
               hist_reg[gi][1] <= row_in[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= S_FILL;
         col_reg        <= '0;
         row_reg        <= '0;
         win_reg        <= '0;
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         if (beat) begin
            col_reg <= col_next;
            if (last_col) begin
               row_reg <= last_row ? '0 : row_reg + RW'(1);
            end
            case (state_reg)
               S_FILL: begin
                  if (last_col && row_reg == RW'(1)) begin
                     state_reg <= S_STREAM;
                  end
               end
               S_STREAM: begin
                  // Columns 0 and 1 lack a full left neighbourhood: no edge windows.
                  if (col_reg >= CW'(2)) begin
                     win_reg       <= win_next;
                     win_valid_reg <= 1'b1;
                  end
                  if (last_col && last_row) begin
                     state_reg <= S_FILL;
                  end
               end
               default: state_reg <= S_FILL;
            endcase
            if (last_col && last_row) begin
               frame_done_reg <= 1'b1;
            end
         end
      end
   end

   assign bus.o_pixel_data       = win_reg;
   assign bus.o_pixel_data_valid = win_valid_reg;
   assign bus.o_frame_done       = frame_done_reg;

endmodule
